// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_pkg
// Purpose  : Shared types for the nibble sequencer and the 4-bit ALU.
// Revision : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_XOR   = 3'd2,
        OP_XNOR  = 3'd3,
        OP_COMP  = 3'd4,
        OP_AND   = 3'd5,
        OP_OR    = 3'd6,
        OP_RSHFT = 3'd7
    } AluSeqOp;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } AluSeqState;

    typedef struct packed {
        logic       carry_in;
        logic       inv_b;
        logic [2:0] func;
    } AluCtrl;

    typedef AluCtrl AluCmd;

    typedef struct packed {
        logic [3:0] d1;
        logic [3:0] d2;
        AluCtrl     ctrl;
    } AluArgs;

    typedef struct packed {
        logic [3:0] res;
        logic       carry_out;
    } AluRet;

    localparam logic [2:0] c_FUNC_ADD = 3'd0;
    localparam logic [2:0] c_FUNC_XOR = 3'd1;
    localparam logic [2:0] c_FUNC_AND = 3'd2;
    localparam logic [2:0] c_FUNC_OR  = 3'd3;
    localparam logic [2:0] c_FUNC_SHR = 3'd4;

    // Don't-care fields of the ALU command table are resolved to 0 here.
    function automatic AluCmd op_to_alucmd(input AluSeqOp op);
        AluCmd cmd;
        cmd = '0;
        case (op)
            OP_ADD:   cmd = '{carry_in: 1'b0, inv_b: 1'b0, func: c_FUNC_ADD};
            OP_SUB:   cmd = '{carry_in: 1'b1, inv_b: 1'b1, func: c_FUNC_ADD};
            OP_COMP:  cmd = '{carry_in: 1'b0, inv_b: 1'b1, func: c_FUNC_ADD};
            OP_XOR:   cmd = '{carry_in: 1'b0, inv_b: 1'b0, func: c_FUNC_XOR};
            OP_XNOR:  cmd = '{carry_in: 1'b0, inv_b: 1'b1, func: c_FUNC_XOR};
            OP_AND:   cmd = '{carry_in: 1'b0, inv_b: 1'b0, func: c_FUNC_AND};
            OP_OR:    cmd = '{carry_in: 1'b0, inv_b: 1'b0, func: c_FUNC_OR};
            OP_RSHFT: cmd = '{carry_in: 1'b0, inv_b: 1'b0, func: c_FUNC_SHR};
            default:  cmd = '0;
        endcase
        return cmd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_nibble_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_nibble_seq_if
// Purpose  : Request/response handshake bundle of the nibble sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_nibble_seq_if
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    AluSeqOp          in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic             out_carry;
    logic             out_eq;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_res, out_carry, out_eq
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_res, out_carry, out_eq
    );
endinterface
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Purpose  : 4-bit combinational ALU driven one nibble at a time.
// Revision : 1.0 - initial release
// ============================================================================
module alu
    import alu_seq_pkg::*;
(
    input  AluArgs args,
    output AluRet  ret
);
    logic [3:0] w_b;
    logic [4:0] w_sum;

    always_comb begin
        w_b   = args.ctrl.inv_b ? ~args.d2 : args.d2;
        w_sum = {1'b0, args.d1} + {1'b0, w_b} + {4'b0000, args.ctrl.carry_in};
        ret   = '0;
        case (args.ctrl.func)
            c_FUNC_ADD: begin
                ret.res       = w_sum[3:0];
                ret.carry_out = w_sum[4];
            end
            c_FUNC_XOR: ret.res = args.d1 ^ w_b;
            c_FUNC_AND: ret.res = args.d1 & args.d2;
            c_FUNC_OR:  ret.res = args.d1 | args.d2;
            // Shift d2 right by one; carry_in fills the MSB, LSB falls out.
            c_FUNC_SHR: begin
                ret.res       = {args.ctrl.carry_in, args.d2[3:1]};
                ret.carry_out = args.d2[0];
            end
            default: ret = '0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/alu_seq_nibble_sel.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_nibble_sel
// Purpose  : Picks the operand nibbles and carry_in for the current step.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_nibble_sel
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IDXW  = 2
) (
    input  AluSeqOp          op,
    input  logic [IDXW-1:0]  idx,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry,
    output AluArgs           args
);
    logic [WIDTH-1:0] w_a_sh;
    logic [WIDTH-1:0] w_b_sh;

    assign w_a_sh = a >> {idx, 2'b00};
    assign w_b_sh = b >> {idx, 2'b00};

    always_comb begin
        args.d1   = w_a_sh[3:0];
        args.d2   = w_b_sh[3:0];
        args.ctrl = op_to_alucmd(op);
        case (op)
            OP_ADD, OP_SUB, OP_COMP: begin
                if (idx != '0) args.ctrl.carry_in = carry;
            end
            // Top nibble sees zero here because the shift already emptied bit 4.
            OP_RSHFT: args.ctrl.carry_in = w_b_sh[4];
            default:  args.ctrl.carry_in = 1'b0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/alu_nibble_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_nibble_seq
// Purpose  : Runs a WIDTH-bit operation through the 4-bit ALU nibble by nibble.
// Revision : 1.0 - initial release
// ============================================================================
module alu_nibble_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    alu_nibble_seq_if.slave        bus,
    output AluArgs                 alu_args,
    input  AluRet                  alu_ret
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] c_IDX_LAST = IDXW'(NIB - 1);

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_width_check
            $error("alu_nibble_seq: WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    AluSeqState       r_state;
    AluSeqState       w_state_nxt;
    AluSeqOp          r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [IDXW-1:0]  r_idx;
    logic             r_carry;
    logic             r_eq;
    AluArgs           w_sel_args;

    alu_seq_nibble_sel #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_sel (
        .op    (r_op),
        .idx   (r_idx),
        .a     (r_a),
        .b     (r_b),
        .carry (r_carry),
        .args  (w_sel_args)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        alu_args    = '0;
        case (r_state)
            ST_IDLE: if (bus.in_valid) w_state_nxt = ST_RUN;
            ST_RUN: begin
                alu_args = w_sel_args;
                if (r_idx == c_IDX_LAST) w_state_nxt = ST_DONE;
            end
            ST_DONE: if (bus.out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op    <= OP_ADD;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_eq    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_op  <= bus.in_op;
                        r_a   <= bus.in_a;
                        r_b   <= bus.in_b;
                        r_idx <= '0;
                        r_eq  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_res[{r_idx, 2'b00} +: 4] <= alu_ret.res;
                    r_carry <= alu_ret.carry_out;
                    r_eq    <= r_eq & (alu_ret.res == 4'hF);
                    r_idx   <= r_idx + IDXW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.out_res   = r_res;
    assign bus.out_carry = r_carry;
    assign bus.out_eq    = (r_op == OP_COMP) & r_eq;
endmodule
`default_nettype wire
